// File: rtl/image_pix_proc_if.sv
// AXI-Stream beat bundle shared by the input and output sides of image_pix_proc.
//   valid : beat valid (source -> sink)
//   data  : packed pixel lanes (source -> sink)
//   last  : last beat of frame (source -> sink)
//   ready : sink can accept (sink -> source)
// master modport drives a stream, slave modport receives one.
interface image_pix_proc_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/image_pix_proc.sv
// Per-pixel point-operation engine on an AXI-Stream path.
// Each beat carries LANES pixels of PIX_WIDTH bits; every lane gets the same
// operation (pass / invert / threshold / saturating offset). Output is a
// registered slice with a one-entry skid buffer, so s_axis.ready is a register.
// Ports:
//   axi_clk, axi_reset_n : clock, synchronous active-low reset
//   s_axis (slave)       : input stream
//   m_axis (master)      : processed output stream, TLAST aligned
//   cfg_mode             : 0 pass, 1 invert, 2 threshold, 3 offset
//   cfg_threshold        : threshold level for mode 2
//   cfg_offset           : signed brightness offset for mode 3
//   frame_done           : one-cycle pulse when the TLAST beat leaves m_axis
//   frame_pixels         : pixel count of the last completed frame
module image_pix_proc #(
  parameter int unsigned PIX_WIDTH = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  image_pix_proc_if.slave      s_axis,
  image_pix_proc_if.master     m_axis,
  input  logic [1:0]           cfg_mode,
  input  logic [PIX_WIDTH-1:0] cfg_threshold,
  input  logic [PIX_WIDTH:0]   cfg_offset,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_pixels
);
  localparam int unsigned DATA_WIDTH = PIX_WIDTH * LANES;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_OFS  = 2'd3
  } mode_t;

  // Offset arithmetic runs at PIX_WIDTH+2 bits: bit PIX_WIDTH+1 flags a
  // negative sum, bit PIX_WIDTH flags an overflow above MAX.
  function automatic logic [PIX_WIDTH-1:0] pix_op(
    input mode_t                mode,
    input logic [PIX_WIDTH-1:0] p,
    input logic [PIX_WIDTH-1:0] thr,
    input logic [PIX_WIDTH:0]   ofs
  );
    logic [PIX_WIDTH+1:0] sum;
    logic [PIX_WIDTH-1:0] res;
    sum = {2'b00, p} + {ofs[PIX_WIDTH], ofs};
    res = p;
    unique case (mode)
      MODE_PASS: res = p;
      MODE_INV:  res = ~p;
      MODE_THR:  res = (p >= thr) ? '1 : '0;
      MODE_OFS: begin
        if (sum[PIX_WIDTH+1])  res = '0;
        else if (sum[PIX_WIDTH]) res = '1;
        else                   res = sum[PIX_WIDTH-1:0];
      end
      default:   res = p;
    endcase
    return res;
  endfunction

  logic                  r_first;
  mode_t                 r_mode;
  logic [PIX_WIDTH-1:0]  r_thr;
  logic [PIX_WIDTH:0]    r_ofs;

  logic                  r_s_ready;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic                  r_sk_valid;
  logic [DATA_WIDTH-1:0] r_sk_data;
  logic                  r_sk_last;

  logic [CNT_WIDTH-1:0]  r_run;
  logic [CNT_WIDTH-1:0]  r_frame_pixels;
  logic                  r_frame_done;

  logic                  w_acc;
  logic                  w_out_free;
  logic                  w_out_xfer;
  mode_t                 w_mode;
  logic [PIX_WIDTH-1:0]  w_thr;
  logic [PIX_WIDTH:0]    w_ofs;
  logic [DATA_WIDTH-1:0] w_proc;
  logic [CNT_WIDTH-1:0]  w_run_next;

  assign w_acc      = s_axis.valid && r_s_ready;
  assign w_out_free = !r_m_valid || m_axis.ready;
  assign w_out_xfer = r_m_valid && m_axis.ready;
  assign w_run_next = r_run + CNT_WIDTH'(LANES);

  // The first beat of a frame uses the live config, which is latched at the
  // same time so the rest of the frame sees the identical settings.
  assign w_mode = r_first ? mode_t'(cfg_mode) : r_mode;
  assign w_thr  = r_first ? cfg_threshold     : r_thr;
  assign w_ofs  = r_first ? cfg_offset        : r_ofs;

  always_comb begin
    w_proc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_proc[i*PIX_WIDTH +: PIX_WIDTH] =
        pix_op(w_mode, s_axis.data[i*PIX_WIDTH +: PIX_WIDTH], w_thr, w_ofs);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_first        <= 1'b1;
      r_mode         <= MODE_PASS;
      r_thr          <= '0;
      r_ofs          <= '0;
      r_s_ready      <= 1'b1;
      r_m_valid      <= 1'b0;
      r_m_data       <= '0;
      r_m_last       <= 1'b0;
      r_sk_valid     <= 1'b0;
      r_sk_data      <= '0;
      r_sk_last      <= 1'b0;
      r_run          <= '0;
      r_frame_pixels <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_first <= s_axis.last;
        if (r_first) begin
          r_mode <= mode_t'(cfg_mode);
          r_thr  <= cfg_threshold;
          r_ofs  <= cfg_offset;
        end
      end

      // A full skid implies s_axis.ready is low, so w_acc cannot coincide
      // with the skid-to-output move.
      if (w_out_free) begin
        if (r_sk_valid) begin
          r_m_valid  <= 1'b1;
          r_m_data   <= r_sk_data;
          r_m_last   <= r_sk_last;
          r_sk_valid <= 1'b0;
          r_s_ready  <= 1'b1;
        end else if (w_acc) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_proc;
          r_m_last  <= s_axis.last;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_proc;
        r_sk_last  <= s_axis.last;
        r_s_ready  <= 1'b0;
      end

      r_frame_done <= 1'b0;
      if (w_out_xfer) begin
        if (r_m_last) begin
          r_frame_pixels <= w_run_next;
          r_run          <= '0;
          r_frame_done   <= 1'b1;
        end else begin
          r_run <= w_run_next;
        end
      end
    end
  end

  assign s_axis.ready = r_s_ready;
  assign m_axis.valid = r_m_valid;
  assign m_axis.data  = r_m_data;
  assign m_axis.last  = r_m_last;
  assign frame_done   = r_frame_done;
  assign frame_pixels = r_frame_pixels;
endmodule

// File: tb/tb_image_pix_proc.sv
module tb_image_pix_proc;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_thr = 8'h00;
  logic [8:0]  cfg_ofs = 9'h000;
  logic        frame_done;
  logic [31:0] frame_pixels;

  always #5 clk = ~clk;

  image_pix_proc_if #(.DATA_WIDTH(DW)) s_if ();
  image_pix_proc_if #(.DATA_WIDTH(DW)) m_if ();

  image_pix_proc #(.PIX_WIDTH(8), .LANES(4), .CNT_WIDTH(32)) dut (
    .axi_clk       (clk),
    .axi_reset_n   (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .cfg_mode      (cfg_mode),
    .cfg_threshold (cfg_thr),
    .cfg_offset    (cfg_ofs),
    .frame_done    (frame_done),
    .frame_pixels  (frame_pixels)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    bp_mode = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 always-ready, 1 pattern 1,0,0,1, 2 random, 3 stalled.
  initial begin
    logic [3:0] pat;
    int         ph;
    pat = 4'b1001;
    ph  = 0;
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: m_if.ready = 1'b1;
        1: begin m_if.ready = pat[ph % 4]; ph++; end
        2: m_if.ready = 1'($urandom_range(0, 1));
        default: m_if.ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  int          inflight = 0;
  logic [31:0] run = '0;
  logic [31:0] exp_fpix = '0;
  logic        exp_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;

  always @(negedge clk) begin
    beat_t b;
    logic  acc, xf;
    if (!rst_n) begin
      exp_q.delete();
      inflight   = 0;
      run        = '0;
      exp_fpix   = '0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", 64'(frame_done), 64'(exp_done));
      check("frame_pixels", 64'(frame_pixels), 64'(exp_fpix));
      check("s_ready", 64'(s_if.ready), 64'(inflight < 2));
      if (prev_stall) begin
        check("stall_valid", 64'(m_if.valid), 64'd1);
        check("stall_beat", 64'({m_if.data, m_if.last}), 64'(prev_beat));
      end
      acc = s_if.valid && s_if.ready;
      xf  = m_if.valid && m_if.ready;
      exp_done = 1'b0;
      if (xf) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none", m_if.data);
        end else begin
          b = exp_q.pop_front();
          check("out_data", 64'(m_if.data), 64'(b.data));
          check("out_last", 64'(m_if.last), 64'(b.last));
          run = run + 32'd4;
          if (b.last) begin
            exp_fpix = run;
            run      = '0;
            exp_done = 1'b1;
          end
        end
      end
      inflight   = inflight + int'(acc) - int'(xf);
      prev_stall = m_if.valid && !m_if.ready;
      prev_beat  = {m_if.data, m_if.last};
    end
  end

  task automatic send(input logic [31:0] d, input logic l, input logic [31:0] e);
    int n;
    exp_q.push_back('{data: e, last: l});
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    n = 0;
    @(negedge clk);
    while (!s_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_if.ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    check("rst_m_data", 64'(m_if.data), 64'd0);
    check("rst_m_last", 64'(m_if.last), 64'd0);
    check("rst_s_ready", 64'(s_if.ready), 64'd1);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_pixels", 64'(frame_pixels), 64'd0);
    @(posedge clk);
    #1;

    // Invert, single-beat frame, one-cycle latency.
    cfg_mode = 2'd1;
    send(32'h00FF7F10, 1'b1, 32'hFF0080EF);
    @(negedge clk);
    check("latency_valid", 64'(m_if.valid), 64'd1);
    check("latency_data", 64'(m_if.data), 64'hFF0080EF);
    drain();
    check("one_beat_frame_pixels", 64'(frame_pixels), 64'd4);

    // Throughput: four beats in four cycles.
    c0 = cyc;
    send(32'h00FF7F10, 1'b0, 32'hFF0080EF);
    send(32'h01020304, 1'b0, 32'hFEFDFCFB);
    send(32'h80808080, 1'b0, 32'h7F7F7F7F);
    send(32'hFFFFFFFF, 1'b1, 32'h00000000);
    check("throughput_cycles", 64'(cyc - c0), 64'd4);
    drain();

    // Saturating offset, both directions.
    cfg_mode = 2'd3;
    cfg_ofs  = 9'h020;
    send(32'hF0E01000, 1'b1, 32'hFFFF3020);
    cfg_ofs  = 9'h1E0;
    send(32'h10FF2040, 1'b1, 32'h00DF0020);
    drain();

    // Threshold with mid-frame mode change.
    cfg_mode = 2'd2;
    cfg_thr  = 8'h80;
    send(32'h7F80FF00, 1'b0, 32'h00FFFF00);
    cfg_mode = 2'd1;
    send(32'h10203040, 1'b0, 32'h00000000);
    send(32'h90A0B0C0, 1'b1, 32'hFFFFFFFF);
    send(32'h10203040, 1'b1, 32'hEFDFCFBF);
    drain();

    // Five-beat frame count.
    cfg_mode = 2'd0;
    for (int i = 1; i <= 5; i++) send(32'(i * 32'h01010101), 1'(i == 5), 32'(i * 32'h01010101));
    drain();
    check("frame5_pixels", 64'(frame_pixels), 64'd20);

    // Backpressure: fixed pattern then random stalls.
    bp_mode = 1;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'(i == 8), 32'(i));
    drain();
    bp_mode = 2;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'(i == 8), 32'(i));
    drain();
    check("bp_frame_pixels", 64'(frame_pixels), 64'd32);

    // Reset with output stalled and skid full; new frame must latch fresh mode.
    bp_mode = 3;
    @(posedge clk);
    #1;
    send(32'h00000011, 1'b0, 32'h00000011);
    send(32'h00000022, 1'b0, 32'h00000022);
    @(negedge clk);
    check("skid_full_ready", 64'(s_if.ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bp_mode = 0;
    @(negedge clk);
    check("rst2_m_valid", 64'(m_if.valid), 64'd0);
    check("rst2_m_data", 64'(m_if.data), 64'd0);
    check("rst2_m_last", 64'(m_if.last), 64'd0);
    check("rst2_s_ready", 64'(s_if.ready), 64'd1);
    check("rst2_frame_pixels", 64'(frame_pixels), 64'd0);
    @(posedge clk);
    #1;
    cfg_mode = 2'd1;
    send(32'h00FF7F10, 1'b1, 32'hFF0080EF);
    drain();
    check("post_rst_frame_pixels", 64'(frame_pixels), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/image_pix_proc.md
Name: image_pix_proc

Overview:
Parametrised AXI-Stream pixel-point-operation engine. Successor to the fixed 4x8-bit inverter. Sits between the DMA MM2S and S2MM streams.
Applies one of four per-pixel operations to every lane of each beat: pass, invert, threshold or saturating brightness offset. Provides a full-throughput register slice with a skid buffer, so backpressure is correct. Passes TLAST through and reports per-frame pixel counts.

Parameters:
PIX_WIDTH, 8, bits per pixel lane
LANES, 4, pixels per beat; DATA_WIDTH = PIX_WIDTH*LANES
CNT_WIDTH, 32, width of frame pixel counter

Ports:
axi_clk  in  1  single clock
axi_reset_n  in  1  reset, synchronous, active-low
s_axis_valid  in  1  input beat valid
s_axis_data  in  DATA_WIDTH  input pixels; lane i = bits [i*PIX_WIDTH +: PIX_WIDTH]
s_axis_last  in  1  last beat of frame
s_axis_ready  out  1  block can accept a beat
m_axis_valid  out  1  output beat valid
m_axis_data  out  DATA_WIDTH  processed pixels
m_axis_last  out  1  TLAST, aligned with its beat
m_axis_ready  in  1  downstream accepts
cfg_mode  in  2  0 pass, 1 invert, 2 threshold, 3 offset
cfg_threshold  in  PIX_WIDTH  threshold level
cfg_offset  in  PIX_WIDTH+1  signed two's-complement brightness offset
frame_done  out  1  one-cycle pulse when the TLAST beat is accepted at output
frame_pixels  out  CNT_WIDTH  pixel count of the last completed frame

Behaviour:
- Reset (axi_reset_n low at a clock edge): m_axis_valid=0, m_axis_data=0, m_axis_last=0, skid empty, s_axis_ready=1, frame_done=0, frame_pixels=0, running count=0, mode latch=0. Any in-flight beats are discarded.
- Accept rules: an input beat is accepted when s_axis_valid && s_axis_ready. An output beat transfers when m_axis_valid && m_axis_ready.
- s_axis_ready is registered. It equals !skid_full and has no combinational path from m_axis_ready.
- Pipeline: an accepted beat appears on m_axis one cycle later if the output register is empty or draining that cycle. Otherwise it goes to the one-entry skid buffer and s_axis_ready drops the next cycle.
- When the output drains and the skid is full, the skid moves to the output and the skid empties.
- Throughput is one beat per cycle with m_axis_ready held high.
- Beat order is preserved. m_axis_valid never drops without a transfer, and data is stable while stalled.
- Mode latching: cfg_mode, cfg_threshold and cfg_offset are latched on the first accepted beat of a frame. The first beat of a frame is the first beat after reset or after an accepted s_axis_last. The latched values apply to all beats of that frame, including the first. Config changes mid-frame take effect at the next frame.
- Per-lane functions (p is the unsigned pixel, MAX = 2^PIX_WIDTH-1):
  - mode 0: p
  - mode 1: MAX-p
  - mode 2: (p >= threshold) ? MAX : 0
  - mode 3: clamp(p + offset, 0, MAX), evaluated at PIX_WIDTH+2 signed width
- Processing happens on the input side. The skid buffer holds already-processed data.
- Counting: the running count adds LANES on each output transfer. On an output transfer with m_axis_last=1:
  - frame_pixels <= running + LANES
  - the running count clears to 0
  - frame_done pulses for 1 cycle
- Counter wrap is modulo 2^CNT_WIDTH, with no saturation.
- A beat with last=1 that is also the first beat of a frame is valid: the frame is one beat long, and frame_pixels=LANES.
- Simultaneous input accept and output drain with the skid full is not possible, because s_axis_ready=0 in that state.

Test Plan:
- Mode 1, pixels 0x00FF7F10, m_axis_ready=1: m_axis_data=0xFF0080EF one cycle after accept; continuous beats give 1 beat/cycle.
- Mode 3, offset +0x20, input 0xF0E01000: output 0xFFFF3020. Offset -0x20 (0x1E0), input 0x10FF2040: output 0x00DF0020.
- Mode 2, threshold 0x80, input 0x7F80FF00: output 0x00FFFF00. Change cfg_mode to 1 mid-frame: the remaining beats of the frame stay thresholded, and the next frame is inverted.
- Backpressure: stream 8 beats (values 1..8) with m_axis_ready toggling 1,0,0,1, and with random stalls. Output order is exact, s_axis_ready falls only when the skid is full, and data is stable during stalls.
- Frame of 5 beats with last on beat 5: frame_done pulses once on the last output transfer and frame_pixels=20. A 1-beat frame gives frame_pixels=4.
- Assert axi_reset_n low for 1 cycle with the skid full and the output stalled: all outputs reach their reset values, s_axis_ready=1, frame_pixels=0, and the next beat is treated as a frame start.
